// File: rtl/mem_arb_defs.sv
// Shared definitions for the unified-memory port arbiter: FSM states, owner IDs, defaults.
package mem_arb_defs;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    localparam int unsigned MEM_LATENCY_DEFAULT  = 2;
    localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/mem_arb_select.sv
// Winner selection between fetch and data requests, with a saturating
// starvation counter that forces a fetch grant after STARVE_LIMIT data grants.
module mem_arb_select
    import mem_arb_defs::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   i_req,
    input  logic   d_req,
    input  logic   grant_en,
    output owner_t winner,
    output logic   grant
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_cnt;
    logic          starved;

    assign starved = (starve_cnt == SW'(STARVE_LIMIT));
    assign grant   = grant_en && (i_req || d_req);

    always_comb begin
        winner = OWN_FETCH;
        if (d_req && !(i_req && starved)) begin
            winner = OWN_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (winner == OWN_FETCH) begin
                starve_cnt <= '0;
            end else if (i_req && !starved) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access:
// IDLE arbitrates, ACCESS holds the strobes for MEM_LATENCY cycles, RESP pulses valid.
module mem_port_arbiter
    import mem_arb_defs::*;
#(
    parameter int unsigned WORD_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned MEM_LATENCY  = MEM_LATENCY_DEFAULT,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_accept,
    output logic                  i_valid,
    output logic [WORD_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [WORD_WIDTH-1:0] d_wdata,
    output logic                  d_accept,
    output logic                  d_valid,
    output logic [WORD_WIDTH-1:0] d_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    input  logic [WORD_WIDTH-1:0] mem_rdata
);

    localparam int unsigned CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    state_t        state;
    state_t        state_next;
    owner_t        owner;
    owner_t        winner;
    logic          grant;
    logic          grant_en;
    logic [CW-1:0] lat_cnt;

    // Accepts are gated by reset so nothing is taken while reset is asserted.
    assign grant_en = (state == IDLE) && !reset;
    assign i_accept = grant && (winner == OWN_FETCH);
    assign d_accept = grant && (winner == OWN_DATA);

    mem_arb_select #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_select (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .d_req    (d_req),
        .grant_en (grant_en),
        .winner   (winner),
        .grant    (grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant) state_next = ACCESS;
            ACCESS:  if (lat_cnt == '0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes and valids are registered here so they change only on clock edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner     <= OWN_FETCH;
            lat_cnt   <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_valid   <= 1'b0;
            d_valid   <= 1'b0;
        end else begin
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner   <= winner;
                        lat_cnt <= CW'(MEM_LATENCY - 1);
                        if (winner == OWN_FETCH) begin
                            mem_addr  <= i_addr;
                            mem_read  <= 1'b1;
                            mem_write <= 1'b0;
                        end else begin
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_read  <= !d_we;
                            mem_write <= d_we;
                        end
                    end
                end
                ACCESS: begin
                    if (lat_cnt == '0) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (owner == OWN_FETCH) begin
                            i_rdata <= mem_rdata;
                            i_valid <= 1'b1;
                        end else begin
                            if (mem_read) d_rdata <= mem_rdata;
                            d_valid <= 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table with scoreboard plus hand sequences
// for starvation, withdrawal, mid-access reset and latency variants.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_accept, i_valid, d_accept, d_valid, mem_read, mem_write;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        l1_req, l1_iacc, l1_ival, l1_dacc, l1_dval, l1_rd, l1_wr;
    logic [15:0] l1_irdata, l1_drdata, l1_maddr, l1_mwdata, l1_mrdata;
    logic        l5_req, l5_iacc, l5_ival, l5_dacc, l5_dval, l5_rd, l5_wr;
    logic [15:0] l5_irdata, l5_drdata, l5_maddr, l5_mwdata, l5_mrdata;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int strobe_cnt = 0;
    bit sb_on = 1'b0;

    typedef struct {
        logic        i_req;
        logic [15:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [15:0] d_addr;
        logic [15:0] d_wdata;
        logic        own;
        logic [15:0] exp_addr;
        logic        exp_wr;
        logic [15:0] exp_i;
        logic [15:0] exp_d;
    } vec_t;

    vec_t tab[7];
    vec_t q[$];

    always #5 clk = ~clk;

    assign mem_rdata = mem_addr ^ 16'hA5B5;
    assign l1_mrdata = l1_maddr ^ 16'hA5B5;
    assign l5_mrdata = l5_maddr ^ 16'hA5B5;

    mem_port_arbiter #(.WORD_WIDTH(16), .ADDR_WIDTH(16), .MEM_LATENCY(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_accept(i_accept), .i_valid(i_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_accept(d_accept), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.MEM_LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset),
        .i_req(l1_req), .i_addr(16'h0007), .i_accept(l1_iacc), .i_valid(l1_ival), .i_rdata(l1_irdata),
        .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000),
        .d_accept(l1_dacc), .d_valid(l1_dval), .d_rdata(l1_drdata),
        .mem_read(l1_rd), .mem_write(l1_wr), .mem_addr(l1_maddr),
        .mem_wdata(l1_mwdata), .mem_rdata(l1_mrdata)
    );

    mem_port_arbiter #(.MEM_LATENCY(5)) u_l5 (
        .clk(clk), .reset(reset),
        .i_req(l5_req), .i_addr(16'h0007), .i_accept(l5_iacc), .i_valid(l5_ival), .i_rdata(l5_irdata),
        .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000),
        .d_accept(l5_dacc), .d_valid(l5_dval), .d_rdata(l5_drdata),
        .mem_read(l5_rd), .mem_write(l5_wr), .mem_addr(l5_maddr),
        .mem_wdata(l5_mwdata), .mem_rdata(l5_mrdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Returns at the negedge where an accept is seen; n = negedges waited.
    task automatic wait_grant(output bit f, output int n, output bit ok);
        ok = 1'b0;
        f  = 1'b0;
        n  = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (i_accept || d_accept) begin
                chk("accept_excl", {31'd0, i_accept & d_accept}, 32'd0);
                f  = i_accept;
                n  = k;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic drop_reqs();
        i_req = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk) #1;
        drop_reqs();
        reset = 1'b1;
        @(posedge clk) #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        vec_t e;
        cyc++;
        if (mem_read || mem_write) begin
            chk("strobe_excl", {31'd0, mem_read & mem_write}, 32'd0);
        end
        if (sb_on) begin
            if (i_accept || d_accept) begin
                acc_cyc    = cyc;
                strobe_cnt = 0;
            end
            if ((mem_read || mem_write) && q.size() > 0) begin
                strobe_cnt++;
                chk("mem_addr", {16'd0, mem_addr}, {16'd0, q[0].exp_addr});
                chk("mem_write", {31'd0, mem_write}, {31'd0, q[0].exp_wr});
                if (q[0].exp_wr) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, q[0].d_wdata});
            end
            if (i_valid || d_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", {30'd0, i_valid, d_valid}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("valid_owner", {30'd0, i_valid, d_valid}, e.own ? 32'd1 : 32'd2);
                    chk("i_rdata", {16'd0, i_rdata}, {16'd0, e.exp_i});
                    chk("d_rdata", {16'd0, d_rdata}, {16'd0, e.exp_d});
                    chk("latency", cyc - acc_cyc, 32'd3);
                    chk("strobe_width", strobe_cnt, 32'd2);
                end
            end
        end
    end

    initial begin
        bit f, ok, got;
        int n, nd;
        logic [9:0] order;
        int a1, a5, w1, w5, v1, v5;
        bit dr1, dr5;

        //              i_req i_addr    d_req we d_addr    d_wdata   own addr      wr  exp_i     exp_d
        tab[0] = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0010, 1'b0, 16'hA5A5, 16'h0000};
        tab[1] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0200, 16'h1234, 1'b1, 16'h0200, 1'b1, 16'hA5A5, 16'h0000};
        tab[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0300, 16'h0000, 1'b1, 16'h0300, 1'b0, 16'hA5A5, 16'hA6B5};
        tab[3] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'hBEEF, 1'b1, 16'h0040, 1'b1, 16'hA5A5, 16'hA6B5};
        tab[4] = '{1'b1, 16'h0050, 1'b1, 1'b0, 16'h0060, 16'h0000, 1'b1, 16'h0060, 1'b0, 16'hA5A5, 16'hA5D5};
        tab[5] = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 16'h5A4A, 16'hA5D5};
        tab[6] = '{1'b1, 16'h1234, 1'b1, 1'b1, 16'h0001, 16'h5555, 1'b1, 16'h0001, 1'b1, 16'h5A4A, 16'hA5D5};

        reset = 1'b1;
        i_req = 1'b1; i_addr = 16'h0011;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0022; d_wdata = 16'h0000;
        l1_req = 1'b0; l5_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_i_accept", {31'd0, i_accept}, 32'd0);
        chk("rst_d_accept", {31'd0, d_accept}, 32'd0);
        chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rst_valids", {30'd0, i_valid, d_valid}, 32'd0);
        chk("rst_rdata", {i_rdata, d_rdata}, 32'd0);
        chk("rst_mem", {mem_addr, mem_wdata}, 32'd0);
        @(posedge clk) #1;
        drop_reqs();
        reset = 1'b0;

        sb_on = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk) #1;
            i_req = tab[i].i_req; i_addr = tab[i].i_addr;
            d_req = tab[i].d_req; d_we = tab[i].d_we;
            d_addr = tab[i].d_addr; d_wdata = tab[i].d_wdata;
            q.push_back(tab[i]);
            wait_grant(f, n, ok);
            if (ok) begin
                chk("vec_winner", {31'd0, ~f}, {31'd0, tab[i].own});
                chk("vec_accept_delay", n, 32'd1);
            end
            @(posedge clk) #1;
            drop_reqs();
            got = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (q.size() == 0) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) begin
                chk("vec_valid_timeout", 32'd0, 32'd1);
                q.delete();
            end
        end
        sb_on = 1'b0;

        // Both requesters held continuously: D,D,D,D,I repeating, 4 cycles apart.
        pulse_reset();
        i_req = 1'b1; i_addr = 16'h0100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
        order = '0;
        for (int g = 0; g < 10; g++) begin
            wait_grant(f, n, ok);
            order[g] = f;
            if (g > 0 && ok) chk("starve_gap", n, 32'd4);
        end
        chk("starve_order", {22'd0, order}, {22'd0, 10'b1000010000});
        @(posedge clk) #1;
        drop_reqs();
        repeat (6) @(posedge clk);

        // Withdrawn fetch: starve_cnt must freeze at 1 while i_req is low.
        pulse_reset();
        i_req = 1'b1; i_addr = 16'h0400;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0500;
        wait_grant(f, n, ok);
        chk("wd_first_data", {31'd0, f}, 32'd0);
        @(posedge clk) #1;
        i_req = 1'b0;
        for (int g = 0; g < 3; g++) begin
            wait_grant(f, n, ok);
            chk("wd_no_fetch", {31'd0, f}, 32'd0);
        end
        @(posedge clk) #1;
        i_req = 1'b1;
        nd = 0;
        for (int g = 0; g < 6; g++) begin
            wait_grant(f, n, ok);
            if (f || !ok) break;
            nd++;
        end
        chk("wd_data_before_fetch", nd, 32'd3);
        @(posedge clk) #1;
        drop_reqs();
        repeat (6) @(posedge clk);

        // Reset in the second ACCESS cycle of a fetch; held request re-accepted at once.
        @(posedge clk) #1;
        i_req = 1'b1; i_addr = 16'h0033;
        wait_grant(f, n, ok);
        chk("mr_accept", {31'd0, f}, 32'd1);
        @(posedge clk);
        @(posedge clk) #1;
        reset = 1'b1;
        @(negedge clk);
        chk("mr_pre_strobe", {31'd0, mem_read}, 32'd1);
        @(posedge clk) #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mr_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        chk("mr_valids", {30'd0, i_valid, d_valid}, 32'd0);
        chk("mr_regs", {i_rdata, d_rdata}, 32'd0);
        chk("mr_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("mr_reaccept", {31'd0, i_accept}, 32'd1);
        @(posedge clk) #1;
        i_req = 1'b0;
        got = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (i_valid) begin
                got = 1'b1;
                n = k;
                break;
            end
        end
        if (got) begin
            chk("mr_valid_delay", n, 32'd3);
            chk("mr_rdata", {16'd0, i_rdata}, 32'h0000A586);
        end else begin
            chk("mr_valid_timeout", 32'd0, 32'd1);
        end
        repeat (3) @(posedge clk);

        // MEM_LATENCY=1 and MEM_LATENCY=5 instances side by side.
        a1 = -1; a5 = -1; v1 = -1; v5 = -1; w1 = 0; w5 = 0;
        dr1 = 1'b0; dr5 = 1'b0;
        @(posedge clk) #1;
        l1_req = 1'b1; l5_req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (l1_iacc) begin a1 = k; dr1 = 1'b1; end
            if (l5_iacc) begin a5 = k; dr5 = 1'b1; end
            if (l1_rd) w1++;
            if (l5_rd) w5++;
            if (l1_ival && v1 < 0) begin
                v1 = k;
                chk("l1_rdata", {16'd0, l1_irdata}, 32'h0000A5B2);
            end
            if (l5_ival && v5 < 0) begin
                v5 = k;
                chk("l5_rdata", {16'd0, l5_irdata}, 32'h0000A5B2);
            end
            @(posedge clk) #1;
            if (dr1) l1_req = 1'b0;
            if (dr5) l5_req = 1'b0;
        end
        chk("l1_latency", v1 - a1, 32'd2);
        chk("l1_width", w1, 32'd1);
        chk("l5_latency", v5 - a5, 32'd6);
        chk("l5_width", w5, 32'd5);
        chk("l_dvalid", {30'd0, l1_dval, l5_dval}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported unified memory between instruction fetch and data access (LWD/SWD) of the multicycle TSC core. Each client gets a request/accept/valid handshake. The arbiter holds the memory strobes and address for the fixed memory latency, captures read data, and returns it with a one-cycle valid pulse. Data accesses have priority; a starvation counter guarantees forward progress for fetch.

## Interface
- WORD_WIDTH, 16, data word width
- ADDR_WIDTH, 16, address width
- MEM_LATENCY, 2, cycles mem_read/mem_write are held per access; legal range ≥1
- STARVE_LIMIT, 4, consecutive data grants with fetch pending before fetch is forced; legal range ≥1
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- i_req  in  1  fetch request; held with i_addr until i_accept
- i_addr  in  ADDR_WIDTH  fetch address
- i_accept  out  1  one-cycle pulse: fetch request taken
- i_valid  out  1  one-cycle pulse: i_rdata valid
- i_rdata  out  WORD_WIDTH  fetched word, registered
- d_req  in  1  data request; held with d_we, d_addr and d_wdata until d_accept
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  WORD_WIDTH  store data
- d_accept  out  1  one-cycle pulse: data request taken
- d_valid  out  1  one-cycle pulse: read data valid, or write completed
- d_rdata  out  WORD_WIDTH  loaded word, registered
- mem_read, mem_write  out  1  memory strobes
- mem_addr  out  ADDR_WIDTH  registered address
- mem_wdata  out  WORD_WIDTH  registered store data
- mem_rdata  in  WORD_WIDTH  memory read data, valid in the last strobe cycle

## Operation
- States: IDLE, ACCESS, RESP.
- **IDLE**
  - No request: stay in IDLE.
  - Any request: pick a winner, pulse the matching accept (combinational from req and state), latch addr/wdata/we/owner, load the latency counter with MEM_LATENCY-1, go to ACCESS.
- **Arbitration (IDLE only)**
  - Only one requester: it wins.
  - Both requesting: data wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
  - starve_cnt increments on each data grant made while i_req is high, saturating at STARVE_LIMIT.
  - starve_cnt clears on every fetch grant.
- **ACCESS**
  - Drive mem_read (owner is fetch, or data with we=0) or mem_write (data with we=1) from the latched values.
  - Decrement the counter each cycle.
  - Counter = 0: capture mem_rdata into the owner's rdata register (reads only) and go to RESP.
- **RESP**
  - Pulse the owner's valid.
  - The other client's rdata register is untouched.
  - Writes pulse d_valid; d_rdata keeps its previous value.
  - Next state is IDLE. There is no acceptance in RESP.
- Requests made outside IDLE are ignored until IDLE. A requester must hold req; deasserting before accept withdraws the request legally.
- A client may raise its next req in the same cycle as its valid; it is seen in the following IDLE cycle.
- **Reset** (synchronous, also mid-access):
  - state → IDLE, counter and starve_cnt → 0
  - all strobes, accepts and valids → 0
  - i_rdata, d_rdata, mem_addr, mem_wdata → 0
  - An in-flight access is abandoned with no valid; a partial write is the memory's concern.

## Timing
- Accept in cycle t → strobes high t+1 … t+MEM_LATENCY → mem_rdata sampled at the end of t+MEM_LATENCY → valid in t+MEM_LATENCY+1 → IDLE in t+MEM_LATENCY+2.
- Throughput: one access per MEM_LATENCY+2 cycles.
- mem_addr, mem_wdata and the strobes are glitch-free register outputs.
- Accept outputs are combinational, but depend only on the req inputs and registered state; there is no input-to-input loop.
- mem_read and mem_write are never high together. Strobes are 0 in IDLE and RESP.

## Structure
- Shared package `mem_arb_defs`:
  - state encodings IDLE/ACCESS/RESP, in the style of the state_def constants
  - owner IDs OWN_FETCH / OWN_DATA
  - MEM_LATENCY default
- Sub-module `mem_arb_select`: winner selection plus the saturating starve_cnt. Inputs i_req, d_req, grant_en; output winner and grant.
- Top level holds the FSM, latency counter, latched request and rdata registers.

## Test plan
- Fetch only, i_addr=0x0010, mem returns 0xA5A5: i_accept at t, mem_read high for exactly 2 cycles with mem_addr=0x0010, i_valid at t+3 with i_rdata=0xA5A5, d_valid never asserted.
- Data write d_addr=0x0200, d_wdata=0x1234: mem_write for 2 cycles, mem_wdata=0x1234, mem_read=0, d_valid at t+3, d_rdata unchanged.
- i_req and d_req both held continuously, STARVE_LIMIT=4: grant order D,D,D,D,I,D,D,D,D,I…; each grant is 4 cycles apart.
- Reset asserted in the second ACCESS cycle of a read: the next cycle has all strobes/valids 0 and the state is IDLE. A request after reset is accepted in the first cycle with reset low.
- MEM_LATENCY=1 and MEM_LATENCY=5 builds: valid arrives exactly MEM_LATENCY+1 cycles after accept; strobe width equals MEM_LATENCY.
- i_req dropped before accept while d_req is being served: no fetch access is issued; starve_cnt stops incrementing.
